// File: rtl/tsc_stream_rx.sv
// TSC stream receiver: requests a buffer dump on trigger, deserialises
// sd into a byte frame and serves it to the host. Option: RX_TIMEOUT_EN.
module tsc_stream_rx #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          trd,
  input  logic          sd,
  input  logic          cd,
  input  logic [31:0]   trigtm,
  output logic          sbf,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [AW:0]   byte_count,
  output logic [31:0]   trig_time,
  output logic          overflow,
  output logic          frame_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t     state;
  state_t     state_nx;
  logic [7:0] sh;
  logic [7:0] sh_nx;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       full;
  logic       wr_en;
  logic       tmo;
  logic       fin;
  logic [7:0] mem [DEPTH];

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`endif

  // Status outputs decoded straight from the state register
  always_comb begin
    sbf         = (state == REQ) || (state == SHIFT);
    frame_valid = (state == HOLD);
    busy        = (state != IDLE);
  end

  // Byte assembly, write enable and end-of-frame detection
  always_comb begin
    sh_nx     = {sh[6:0], sd};
    byte_done = (state == SHIFT) && (bit_cnt == 3'd7);
    full      = (byte_count == FULL);
    wr_en     = byte_done && !full;
    tmo       = 1'b0;
`ifdef RX_TIMEOUT_EN
    tmo = (state == SHIFT) && !cd &&
          (to_cnt == TW'(TIMEOUT - 1));
`endif
    fin = (state == SHIFT) && (cd || tmo);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (trd && !frame_valid) state_nx = REQ;
      REQ:   state_nx = SHIFT;
      SHIFT: if (fin) state_nx = HOLD;
      HOLD:  if (frame_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame bookkeeping: shifter, counters, flags, timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh         <= '0;
      bit_cnt    <= '0;
      byte_count <= '0;
      trig_time  <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (trd) begin
            trig_time  <= trigtm;
            byte_count <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            sh         <= '0;
            bit_cnt    <= '0;
          end
        end
        REQ: begin
`ifdef RX_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        SHIFT: begin
          sh      <= sh_nx;
          bit_cnt <= bit_cnt + 3'd1;
`ifdef RX_TIMEOUT_EN
          to_cnt  <= to_cnt + TW'(1);
`endif
          if (byte_done) begin
            if (full) overflow <= 1'b1;
            else byte_count <= byte_count + (AW+1)'(1);
          end
          if (fin) begin
            sh      <= '0;
            bit_cnt <= '0;
            if (cd && bit_cnt != 3'd7) frame_err <= 1'b1;
            if (tmo) frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[byte_count[AW-1:0]] <= sh_nx;
  end

  // Registered host read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_tsc_stream_rx.sv
// Directed bench for tsc_stream_rx: frame capture, partial byte,
// overflow, hold/ack handshake and mid-transfer reset.
module tb_tsc_stream_rx;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          trd;
  logic          sd;
  logic          cd;
  logic [31:0]   trigtm;
  logic          sbf;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic          frame_ack;
  logic [AW:0]   byte_count;
  logic [31:0]   trig_time;
  logic          overflow;
  logic          frame_err;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int sbf_cnt = 0;

  tsc_stream_rx #(
    .DEPTH(DEPTH),
    .AW(AW),
    .TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .trd(trd),
    .sd(sd),
    .cd(cd),
    .trigtm(trigtm),
    .sbf(sbf),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .byte_count(byte_count),
    .trig_time(trig_time),
    .overflow(overflow),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sbf === 1'b1) sbf_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic c);
    sd = b;
    cd = c;
    step();
    cd = 1'b0;
    sd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    for (int i = 7; i >= 0; i--)
      send_bit(b[i], last && (i == 0));
  endtask

  task automatic start_frame();
    trd = 1'b1;
    step();
    trd = 1'b0;
    step();
  endtask

  task automatic read_chk(input string tag,
                          input logic [AW-1:0] a,
                          input logic [7:0] exp);
    rd_addr = a;
    step();
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    trd       = 1'b0;
    sd        = 1'b0;
    cd        = 1'b0;
    trigtm    = 32'd0;
    rd_addr   = '0;
    frame_ack = 1'b0;
    step();
    step();
    chk("rst_sbf", {31'd0, sbf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_bc", {26'd0, byte_count}, 32'd0);
    chk("rst_tt", trig_time, 32'd0);
    chk("rst_rd", {24'd0, rd_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    step();

    // stray ack and cd while idle do nothing
    frame_ack = 1'b1;
    cd = 1'b1;
    step();
    frame_ack = 1'b0;
    cd = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // basic 32-byte frame
    sbf_cnt = 0;
    trigtm = 32'h0000_0019;
    trd = 1'b1;
    step();
    trd = 1'b0;
    trigtm = 32'h0;
    chk("req_sbf", {31'd0, sbf}, 32'd1);
    step();
    for (int i = 0; i < 32; i++)
      send_byte(8'(i), i == 31);
    chk("b_fv", {31'd0, frame_valid}, 32'd1);
    chk("b_bc", {26'd0, byte_count}, 32'd32);
    chk("b_tt", trig_time, 32'h19);
    chk("b_err", {31'd0, frame_err}, 32'd0);
    chk("b_ovf", {31'd0, overflow}, 32'd0);
    chk("b_sbf", {31'd0, sbf}, 32'd0);
    chk("b_sbfcnt", sbf_cnt, 32'd257);
    read_chk("b_rd5", 5'd5, 8'h05);
    read_chk("b_rd0", 5'd0, 8'h00);
    read_chk("b_rd31", 5'd31, 8'h1F);

    // trigger while holding is ignored; ack with trd held
    trigtm = 32'h0000_00AB;
    trd = 1'b1;
    step();
    chk("h_sbf", {31'd0, sbf}, 32'd0);
    chk("h_fv", {31'd0, frame_valid}, 32'd1);
    chk("h_tt", trig_time, 32'h19);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("a_fv", {31'd0, frame_valid}, 32'd0);
    chk("a_sbf", {31'd0, sbf}, 32'd0);
    step();
    trd = 1'b0;
    chk("a_req", {31'd0, sbf}, 32'd1);
    chk("a_tt", trig_time, 32'hAB);
    step();

    // partial byte: D0, C8 then 3 bits
    send_byte(8'hD0, 1'b0);
    send_byte(8'hC8, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("p_fv", {31'd0, frame_valid}, 32'd1);
    chk("p_bc", {26'd0, byte_count}, 32'd2);
    chk("p_err", {31'd0, frame_err}, 32'd1);
    read_chk("p_rd0", 5'd0, 8'hD0);
    read_chk("p_rd1", 5'd1, 8'hC8);
    ack();
    chk("p_busy", {31'd0, busy}, 32'd0);

    // overflow: 34 bytes 0x40..0x61 into 32 slots
    start_frame();
    chk("o_clr", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < 34; i++)
      send_byte(8'(8'h40 + i), i == 33);
    chk("o_bc", {26'd0, byte_count}, 32'd32);
    chk("o_ovf", {31'd0, overflow}, 32'd1);
    chk("o_err", {31'd0, frame_err}, 32'd0);
    read_chk("o_rd31", 5'd31, 8'h5F);
    read_chk("o_rd0", 5'd0, 8'h40);
    ack();

    // reset after 10 bits of a new frame
    start_frame();
    for (int i = 0; i < 10; i++)
      send_bit(i[0], 1'b0);
    chk("m_busy0", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("m_sbf", {31'd0, sbf}, 32'd0);
    chk("m_busy", {31'd0, busy}, 32'd0);
    chk("m_bc", {26'd0, byte_count}, 32'd0);
    chk("m_ovf", {31'd0, overflow}, 32'd0);
    step();
    reset_n = 1'b1;
    cd = 1'b1;
    step();
    cd = 1'b0;
    step();
    step();
    chk("m_fv", {31'd0, frame_valid}, 32'd0);
    chk("m_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tsc_stream_rx.md
Name: tsc_stream_rx

Overview:
- Downstream consumer of the TSC sample stream.
- On a TSC trigger (trd), requests a buffer dump by asserting sbf, deserialises the bit stream on sd into bytes, and stores them in an internal byte buffer.
- Latches the TSC trigger timestamp (trigtm) alongside the frame.
- Presents the completed frame to the host side through a random-read port with a valid/ack handshake.

Parameters:
- DEPTH, 32, byte capacity of the frame buffer; power of two, 2..256.
- AW, 5, read-address width; must equal log2(DEPTH).
- TIMEOUT, 1024, cycles allowed from sbf assertion to cd; used only with RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- trd  in  1  TSC trigger-detected level.
- sd  in  1  TSC serial data, one bit per clk, MSB first.
- cd  in  1  TSC transfer complete; high coincident with the final bit.
- trigtm  in  32  TSC trigger timestamp.
- sbf  out  1  send-buffer request to TSC.
- rd_addr  in  AW  host read address.
- rd_data  out  8  byte at rd_addr, registered (1-cycle latency).
- frame_valid  out  1  a complete frame is held.
- frame_ack  in  1  host releases the frame.
- byte_count  out  AW+1  complete bytes stored in the frame, 0..DEPTH.
- trig_time  out  32  trigtm latched for this frame.
- overflow  out  1  more than DEPTH bytes arrived.
- frame_err  out  1  cd arrived with a partial byte, or a timeout occurred.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - sbf, frame_valid, overflow, frame_err, busy = 0.
  - byte_count = 0, trig_time = 0, rd_data = 0.
  - Shift register and bit counter are cleared.
  - Buffer contents are don't-care.
  - Reset asserted mid-transfer aborts immediately with no frame kept.
- State machine: IDLE, REQ, SHIFT, HOLD.
- IDLE:
  - When trd=1 and frame_valid=0: latch trig_time<=trigtm, clear byte_count, overflow and frame_err, then go to REQ.
  - When trd=1 and frame_valid=1, the trigger is ignored and the block stays in IDLE.
- REQ:
  - sbf=1 for exactly this cycle and all SHIFT cycles.
  - Always go to SHIFT next cycle.
- SHIFT: sd is sampled on every rising edge into an 8-bit shift register, MSB first.
  - Every 8th bit writes the assembled byte to buf[byte_count] and increments byte_count.
  - A write with byte_count==DEPTH is dropped and sets overflow; byte_count saturates at DEPTH.
  - On the edge where cd=1, the final bit is sampled first and any completed byte is written.
  - If that edge leaves the bit counter non-zero, set frame_err and discard the partial byte.
  - Then: sbf<=0, frame_valid<=1, go to HOLD.
- HOLD:
  - frame_valid=1.
  - When frame_ack=1: frame_valid<=0, go to IDLE.
  - If trd is still 1 on the ack cycle, the next frame starts on the following cycle, not the same one.
- Read port:
  - rd_data <= buf[rd_addr] every cycle.
  - Reads are legal in any state; data is defined only for addresses below byte_count while frame_valid=1.
  - Read and write to the same address in the same cycle returns the old byte.
- Simultaneous events:
  - frame_ack outside HOLD is ignored.
  - cd outside SHIFT is ignored.
  - trd changing during SHIFT is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 in REQ and increments each SHIFT cycle.
  - If it reaches TIMEOUT with no cd: set frame_err, sbf<=0, frame_valid<=1 with whatever complete bytes are stored, go to HOLD.
- Undefined:
  - The counter and the TIMEOUT check are absent.
  - SHIFT waits for cd indefinitely; frame_err reflects partial bytes only.

Test Plan:
- Basic frame: trigtm=0x00000019, trd pulse, 32 bytes 0x00..0x1F MSB first, cd on bit 256 -> sbf high 257 cycles, frame_valid=1, byte_count=32, trig_time=0x19, rd_addr=5 gives rd_data=0x05 one cycle later, frame_err=0.
- Partial byte: 2 bytes (0xD0, 0xC8) plus 3 bits, then cd -> byte_count=2, frame_err=1, buf[0]=0xD0, buf[1]=0xC8.
- Overflow: 34 bytes with DEPTH=32 -> byte_count=32, overflow=1, buf[31] = the 32nd byte.
- Hold/ack: second trd while frame_valid=1 -> ignored, sbf stays 0; frame_ack -> frame_valid=0 next cycle; trd still high -> REQ the cycle after.
- Mid-transfer reset: reset_n=0 after 10 bits -> sbf=0, busy=0, byte_count=0 immediately; no frame_valid after release.
- RX_TIMEOUT_EN with TIMEOUT=64: 5 bytes, no cd -> 64 cycles after REQ, frame_err=1, frame_valid=1, byte_count=5, sbf=0.
